// File: rtl/ysyx_23060124_pkg.sv
// rtl/ysyx_23060124_pkg.sv - shared types and default widths for the ysyx_23060124 writeback unit
//
// Holds the writeback state encoding, the redirect flag group, the queue
// entry layout at default widths and the default parameter values.
package ysyx_23060124_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int RF_ADDR_W_DEF  = 4;
    localparam int CSR_ADDR_W_DEF = 12;
    localparam int DEPTH_DEF      = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        HALT  = 2'd2
    } wbu_state_e;

    typedef struct packed {
        logic brch;
        logic jal;
        logic jalr;
        logic ecall;
        logic mret;
    } wbu_redir_t;

    // Entry layout at the default widths; the top builds the same layout
    // from its own parameters.
    typedef struct packed {
        logic                      wen;
        logic                      csr_wen;
        logic [RF_ADDR_W_DEF-1:0]  rd_addr;
        logic [CSR_ADDR_W_DEF-1:0] csr_addr;
        wbu_redir_t                redir;
        logic                      ebreak;
        logic [XLEN_DEF-1:0]       pc_next;
        logic [XLEN_DEF-1:0]       res;
    } wbu_entry_t;

    function automatic logic is_redirect(input wbu_redir_t r);
        return |r;
    endfunction

endpackage

// File: rtl/ysyx_23060124_wbu_fifo.sv
// rtl/ysyx_23060124_wbu_fifo.sv - synchronous in-order FIFO with flush and occupancy count
//
// Ports:
//   clock, reset      clock and synchronous active-low reset
//   i_push, i_wdata   write at tail (caller guarantees not full)
//   i_pop             drop head (caller guarantees not empty)
//   i_flush           empty the queue; overrides push and pop on the same edge
//   o_rdata           head entry (valid when o_count != 0)
//   o_count           number of stored entries
module ysyx_23060124_wbu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset: contents are only observed through the count.
    always_ff @(posedge clock) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/ysyx_23060124_wbu_pipe.sv
// rtl/ysyx_23060124_wbu_pipe.sv - writeback unit: result queue, registered GPR/CSR writes, redirect and halt
//
// Optional feature macro: YSYX_23060124_WBU_DIFFTEST_EN adds o_diff_commit
// (per-retirement pulse) and o_commit_cnt (64-bit retired counter).
//
// Ports:
//   clock, reset                      clock and synchronous active-low reset
//   i_pre_valid / o_pre_ready         upstream handshake
//   i_wen, i_csr_wen, i_rd_addr,
//   i_csr_addr, i_res                 write request fields
//   i_brch, i_jal, i_jalr, i_ecall,
//   i_mret, i_pc_next                 redirect sources and target
//   i_ebreak                          halt request
//   o_wbu_wen, o_wbu_csr_wen          one-cycle write strobes
//   o_rd_addr, o_rd_wdata,
//   o_csr_addr, o_csr_rd_wdata        registered write address/data
//   o_pc_update, o_pc_next            one-cycle redirect pulse and target
//   o_halt                            ebreak retired
module ysyx_23060124_wbu_pipe
    import ysyx_23060124_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int RF_ADDR_W  = RF_ADDR_W_DEF,
    parameter int CSR_ADDR_W = CSR_ADDR_W_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_pre_valid,
    output logic                  o_pre_ready,
    input  logic                  i_wen,
    input  logic                  i_csr_wen,
    input  logic [RF_ADDR_W-1:0]  i_rd_addr,
    input  logic [CSR_ADDR_W-1:0] i_csr_addr,
    input  logic                  i_brch,
    input  logic                  i_jal,
    input  logic                  i_jalr,
    input  logic                  i_ecall,
    input  logic                  i_mret,
    input  logic                  i_ebreak,
    input  logic [XLEN-1:0]       i_pc_next,
    input  logic [XLEN-1:0]       i_res,
    output logic                  o_wbu_wen,
    output logic                  o_wbu_csr_wen,
    output logic [RF_ADDR_W-1:0]  o_rd_addr,
    output logic [CSR_ADDR_W-1:0] o_csr_addr,
    output logic [XLEN-1:0]       o_rd_wdata,
    output logic [XLEN-1:0]       o_csr_rd_wdata,
    output logic                  o_pc_update,
    output logic [XLEN-1:0]       o_pc_next,
    output logic                  o_halt
`ifdef YSYX_23060124_WBU_DIFFTEST_EN
    ,
    output logic                  o_diff_commit,
    output logic [63:0]           o_commit_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic                   wen;
        logic                   csr_wen;
        logic [RF_ADDR_W-1:0]   rd_addr;
        logic [CSR_ADDR_W-1:0]  csr_addr;
        wbu_redir_t             redir;
        logic                   ebreak;
        logic [XLEN-1:0]        pc_next;
        logic [XLEN-1:0]        res;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    wbu_state_e              r_state;
    logic                    r_wen;
    logic                    r_csr_wen;
    logic [RF_ADDR_W-1:0]    r_rd_addr;
    logic [CSR_ADDR_W-1:0]   r_csr_addr;
    logic [XLEN-1:0]         r_rd_wdata;
    logic [XLEN-1:0]         r_csr_wdata;
    logic                    r_pc_update;
    logic [XLEN-1:0]         r_pc_next;
    logic                    r_halt;

    entry_t                  w_in;
    entry_t                  w_head;
    logic [ENTRY_W-1:0]      w_head_bits;
    logic [CNT_W-1:0]        w_count;
    logic                    w_push;
    logic                    w_retire;
    logic                    w_head_redir;
    logic                    w_flush;

    assign w_in.wen        = i_wen;
    assign w_in.csr_wen    = i_csr_wen;
    assign w_in.rd_addr    = i_rd_addr;
    assign w_in.csr_addr   = i_csr_addr;
    assign w_in.redir.brch = i_brch;
    assign w_in.redir.jal  = i_jal;
    assign w_in.redir.jalr = i_jalr;
    assign w_in.redir.ecall = i_ecall;
    assign w_in.redir.mret = i_mret;
    assign w_in.ebreak     = i_ebreak;
    assign w_in.pc_next    = i_pc_next;
    assign w_in.res        = i_res;

    assign o_pre_ready  = (w_count != CNT_W'(DEPTH)) && (r_state == RUN);
    assign w_push       = i_pre_valid && o_pre_ready;
    assign w_retire     = (r_state == RUN) && (w_count != '0);
    assign w_head       = entry_t'(w_head_bits);
    assign w_head_redir = is_redirect(w_head.redir);
    // A redirecting retirement discards everything behind it, including an
    // entry being pushed on the same edge. ebreak wins over redirect flags.
    assign w_flush      = w_retire && !w_head.ebreak && w_head_redir;

    ysyx_23060124_wbu_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_retire),
        .i_flush (w_flush),
        .i_wdata (w_in),
        .o_rdata (w_head_bits),
        .o_count (w_count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= RUN;
            r_wen       <= 1'b0;
            r_csr_wen   <= 1'b0;
            r_rd_addr   <= '0;
            r_csr_addr  <= '0;
            r_rd_wdata  <= '0;
            r_csr_wdata <= '0;
            r_pc_update <= 1'b0;
            r_pc_next   <= '0;
            r_halt      <= 1'b0;
        end else begin
            r_wen       <= 1'b0;
            r_csr_wen   <= 1'b0;
            r_pc_update <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_retire) begin
                        if (w_head.ebreak) begin
                            r_state <= HALT;
                            r_halt  <= 1'b1;
                        end else begin
                            r_wen       <= w_head.wen && (w_head.rd_addr != '0);
                            r_csr_wen   <= w_head.csr_wen;
                            r_rd_addr   <= w_head.rd_addr;
                            r_csr_addr  <= w_head.csr_addr;
                            r_rd_wdata  <= w_head.res;
                            r_csr_wdata <= w_head.res;
                            if (w_head_redir) begin
                                r_state     <= REDIR;
                                r_pc_update <= 1'b1;
                                r_pc_next   <= w_head.pc_next;
                            end
                        end
                    end
                end
                REDIR:   r_state <= RUN;
                HALT:    r_state <= HALT;
                default: r_state <= RUN;
            endcase
        end
    end

    assign o_wbu_wen      = r_wen;
    assign o_wbu_csr_wen  = r_csr_wen;
    assign o_rd_addr      = r_rd_addr;
    assign o_csr_addr     = r_csr_addr;
    assign o_rd_wdata     = r_rd_wdata;
    assign o_csr_rd_wdata = r_csr_wdata;
    assign o_pc_update    = r_pc_update;
    assign o_pc_next      = r_pc_next;
    assign o_halt         = r_halt;

`ifdef YSYX_23060124_WBU_DIFFTEST_EN
    logic        r_diff_commit;
    logic [63:0] r_commit_cnt;

    // Every pop is a real retirement; flushed entries are never popped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_diff_commit <= 1'b0;
            r_commit_cnt  <= 64'd0;
        end else begin
            r_diff_commit <= w_retire;
            if (w_retire) begin
                r_commit_cnt <= r_commit_cnt + 64'd1;
            end
        end
    end

    assign o_diff_commit = r_diff_commit;
    assign o_commit_cnt  = r_commit_cnt;
`endif

endmodule

// File: tb/tb_ysyx_23060124_wbu_pipe.sv
// tb/tb_ysyx_23060124_wbu_pipe.sv - directed table-driven bench for ysyx_23060124_wbu_pipe
module tb_ysyx_23060124_wbu_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_pre_valid = 1'b0;
    logic        o_pre_ready;
    logic        i_wen = 1'b0, i_csr_wen = 1'b0;
    logic [3:0]  i_rd_addr = '0;
    logic [11:0] i_csr_addr = '0;
    logic        i_brch = 1'b0, i_jal = 1'b0, i_jalr = 1'b0, i_ecall = 1'b0, i_mret = 1'b0;
    logic        i_ebreak = 1'b0;
    logic [31:0] i_pc_next = '0, i_res = '0;
    logic        o_wbu_wen, o_wbu_csr_wen;
    logic [3:0]  o_rd_addr;
    logic [11:0] o_csr_addr;
    logic [31:0] o_rd_wdata, o_csr_rd_wdata;
    logic        o_pc_update;
    logic [31:0] o_pc_next;
    logic        o_halt;
`ifdef YSYX_23060124_WBU_DIFFTEST_EN
    logic        o_diff_commit;
    logic [63:0] o_commit_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    always #5 clock = ~clock;

    ysyx_23060124_wbu_pipe dut (
        .clock          (clock),
        .reset          (reset),
        .i_pre_valid    (i_pre_valid),
        .o_pre_ready    (o_pre_ready),
        .i_wen          (i_wen),
        .i_csr_wen      (i_csr_wen),
        .i_rd_addr      (i_rd_addr),
        .i_csr_addr     (i_csr_addr),
        .i_brch         (i_brch),
        .i_jal          (i_jal),
        .i_jalr         (i_jalr),
        .i_ecall        (i_ecall),
        .i_mret         (i_mret),
        .i_ebreak       (i_ebreak),
        .i_pc_next      (i_pc_next),
        .i_res          (i_res),
        .o_wbu_wen      (o_wbu_wen),
        .o_wbu_csr_wen  (o_wbu_csr_wen),
        .o_rd_addr      (o_rd_addr),
        .o_csr_addr     (o_csr_addr),
        .o_rd_wdata     (o_rd_wdata),
        .o_csr_rd_wdata (o_csr_rd_wdata),
        .o_pc_update    (o_pc_update),
        .o_pc_next      (o_pc_next),
        .o_halt         (o_halt)
`ifdef YSYX_23060124_WBU_DIFFTEST_EN
        ,
        .o_diff_commit  (o_diff_commit),
        .o_commit_cnt   (o_commit_cnt)
`endif
    );

    typedef struct {
        logic        wen;
        logic        csr_wen;
        logic [3:0]  rd;
        logic [11:0] csr;
        logic [4:0]  redir;   // {brch, jal, jalr, ecall, mret}
        logic [31:0] pc;
        logic [31:0] res;
        logic        x_wen;
        logic        x_csr_wen;
        logic        x_pcu;
        logic [31:0] x_pc_next;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
`ifdef YSYX_23060124_WBU_DIFFTEST_EN
        if (o_diff_commit) n_pulses++;
`endif
    endtask

    task automatic drive(input logic wen, input logic csr_wen, input logic [3:0] rd,
                         input logic [11:0] csr, input logic [4:0] redir, input logic ebreak,
                         input logic [31:0] pc, input logic [31:0] res);
        i_pre_valid = 1'b1;
        i_wen       = wen;
        i_csr_wen   = csr_wen;
        i_rd_addr   = rd;
        i_csr_addr  = csr;
        {i_brch, i_jal, i_jalr, i_ecall, i_mret} = redir;
        i_ebreak    = ebreak;
        i_pc_next   = pc;
        i_res       = res;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 12'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        i_pre_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic wen, input logic csr_wen, input logic [3:0] rd,
                                input logic [11:0] csr, input logic [4:0] redir,
                                input logic [31:0] pc, input logic [31:0] res,
                                input logic x_wen, input logic x_csr_wen, input logic x_pcu,
                                input logic [31:0] x_pc_next);
        vec_t v;
        v.wen = wen; v.csr_wen = csr_wen; v.rd = rd; v.csr = csr; v.redir = redir;
        v.pc = pc; v.res = res; v.x_wen = x_wen; v.x_csr_wen = x_csr_wen;
        v.x_pcu = x_pcu; v.x_pc_next = x_pc_next;
        return v;
    endfunction

    task automatic push_wait(input logic [3:0] rd, input logic [4:0] redir, input logic [31:0] pc,
                             input logic [31:0] res);
        int waited = 0;
        while (!o_pre_ready && waited < 20) begin
            step();
            waited++;
        end
        if (waited >= 20) check("push_wait_timeout", 64'(o_pre_ready), 64'd1);
        drive(1'b1, 1'b0, rd, 12'd0, redir, 1'b0, pc, res);
        step();
    endtask

    logic [3:0]  bp_rd  [3];
    logic [31:0] bp_res [3];

    initial begin
        // brch jal jalr ecall mret
        vecs[0] = mk(1, 0, 4'd5,  12'h000, 5'b00000, 32'h0,        32'hDEADBEEF, 1, 0, 0, 32'h0);
        vecs[1] = mk(1, 0, 4'd0,  12'h000, 5'b00000, 32'h0,        32'h00001234, 0, 0, 0, 32'h0);
        vecs[2] = mk(0, 1, 4'd0,  12'h341, 5'b00000, 32'h0,        32'h80000004, 0, 1, 0, 32'h0);
        vecs[3] = mk(1, 0, 4'd1,  12'h000, 5'b01000, 32'h80000100, 32'h80000008, 1, 0, 1, 32'h80000100);
        vecs[4] = mk(0, 1, 4'd0,  12'h341, 5'b00010, 32'h80000200, 32'h80000010, 0, 1, 1, 32'h80000200);
        vecs[5] = mk(0, 0, 4'd0,  12'h000, 5'b10000, 32'h80000040, 32'h00000000, 0, 0, 1, 32'h80000040);
        vecs[6] = mk(0, 0, 4'd0,  12'h000, 5'b00001, 32'h80000300, 32'h00000000, 0, 0, 1, 32'h80000300);
        vecs[7] = mk(1, 0, 4'd15, 12'h000, 5'b00000, 32'hFFFFFFFF, 32'h0000000F, 1, 0, 0, 32'h80000300);

        // Reset held for two edges
        reset = 1'b0;
        step();
        step();
        check("rst_wen",      64'(o_wbu_wen), 64'd0);
        check("rst_csr_wen",  64'(o_wbu_csr_wen), 64'd0);
        check("rst_rd_addr",  64'(o_rd_addr), 64'd0);
        check("rst_csr_addr", 64'(o_csr_addr), 64'd0);
        check("rst_rd_wdata", 64'(o_rd_wdata), 64'd0);
        check("rst_csr_data", 64'(o_csr_rd_wdata), 64'd0);
        check("rst_pc_upd",   64'(o_pc_update), 64'd0);
        check("rst_pc_next",  64'(o_pc_next), 64'd0);
        check("rst_halt",     64'(o_halt), 64'd0);
        reset = 1'b1;
        step();
        check("rst_ready",    64'(o_pre_ready), 64'd1);

        // Single-entry vectors: accept at edge N, observe after edge N+1
        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].wen, vecs[k].csr_wen, vecs[k].rd, vecs[k].csr, vecs[k].redir, 1'b0,
                  vecs[k].pc, vecs[k].res);
            check("vec_ready_in", 64'(o_pre_ready), 64'd1);
            step();
            idle();
            check("vec_no_early", 64'(o_wbu_wen | o_wbu_csr_wen | o_pc_update), 64'd0);
            step();
            check("vec_wen",      64'(o_wbu_wen), 64'(vecs[k].x_wen));
            check("vec_csr_wen",  64'(o_wbu_csr_wen), 64'(vecs[k].x_csr_wen));
            check("vec_pc_upd",   64'(o_pc_update), 64'(vecs[k].x_pcu));
            check("vec_pc_next",  64'(o_pc_next), 64'(vecs[k].x_pc_next));
            check("vec_rd_addr",  64'(o_rd_addr), 64'(vecs[k].rd));
            check("vec_rd_wdata", 64'(o_rd_wdata), 64'(vecs[k].res));
            check("vec_csr_addr", 64'(o_csr_addr), 64'(vecs[k].csr));
            check("vec_csr_data", 64'(o_csr_rd_wdata), 64'(vecs[k].res));
            check("vec_ready_out", 64'(o_pre_ready), 64'(!vecs[k].x_pcu));
            step();
            check("vec_strobe_1cyc", 64'(o_wbu_wen | o_wbu_csr_wen | o_pc_update), 64'd0);
            check("vec_ready_after", 64'(o_pre_ready), 64'd1);
        end

        // Three back-to-back entries through a 2-deep queue
        bp_rd[0] = 4'd2; bp_rd[1] = 4'd3; bp_rd[2] = 4'd4;
        bp_res[0] = 32'h0000000A; bp_res[1] = 32'h0000000B; bp_res[2] = 32'h0000000C;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                drive(1'b1, 1'b0, bp_rd[k], 12'd0, 5'd0, 1'b0, 32'd0, bp_res[k]);
                check("bp_ready", 64'(o_pre_ready), 64'd1);
            end else begin
                idle();
            end
            step();
            if (k >= 1) begin
                check("bp_wen",   64'(o_wbu_wen), 64'd1);
                check("bp_rd",    64'(o_rd_addr), 64'(bp_rd[k-1]));
                check("bp_wdata", 64'(o_rd_wdata), 64'(bp_res[k-1]));
            end
        end
        check("bp_last_rd", 64'(o_rd_addr), 64'd4);
        step();
        check("bp_drained", 64'(o_wbu_wen), 64'd0);

        // jal followed by add accepted on the jal's retirement edge
        drive(1'b1, 1'b0, 4'd1, 12'd0, 5'b01000, 1'b0, 32'h80000100, 32'h80000004);
        step();
        drive(1'b1, 1'b0, 4'd7, 12'd0, 5'b00000, 1'b0, 32'd0, 32'h00000077);
        check("fl_ready_add", 64'(o_pre_ready), 64'd1);
        step();
        idle();
        check("fl_pc_upd",  64'(o_pc_update), 64'd1);
        check("fl_pc_next", 64'(o_pc_next), 64'h80000100);
        check("fl_wen",     64'(o_wbu_wen), 64'd1);
        check("fl_rd",      64'(o_rd_addr), 64'd1);
        check("fl_ready0",  64'(o_pre_ready), 64'd0);
        step();
        check("fl_pc_upd_1cyc", 64'(o_pc_update), 64'd0);
        check("fl_ready1",  64'(o_pre_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("fl_add_never", 64'(o_wbu_wen), 64'd0);
            step();
        end
        check("fl_rd_held", 64'(o_rd_addr), 64'd1);

        // ebreak with a jal flag set: halt wins, no writes, no redirect
        drive(1'b1, 1'b0, 4'd3, 12'd0, 5'b01000, 1'b1, 32'h80000500, 32'h00000099);
        step();
        idle();
        step();
        check("halt_set",    64'(o_halt), 64'd1);
        check("halt_no_wen", 64'(o_wbu_wen), 64'd0);
        check("halt_no_pcu", 64'(o_pc_update), 64'd0);
        check("halt_pc_hold", 64'(o_pc_next), 64'h80000100);
        drive(1'b1, 1'b0, 4'd6, 12'd0, 5'd0, 1'b0, 32'd0, 32'h66);
        for (int k = 0; k < 100; k++) begin
            check("halt_hold", {61'd0, o_halt, o_pre_ready, o_wbu_wen}, 64'b100);
            step();
        end
        idle();
        reset = 1'b0;
        step();
        check("halt_rst_halt", 64'(o_halt), 64'd0);
        check("halt_rst_pcnx", 64'(o_pc_next), 64'd0);
        reset = 1'b1;
        step();
        check("halt_rst_ready", 64'(o_pre_ready), 64'd1);

`ifdef YSYX_23060124_WBU_DIFFTEST_EN
        check("dt_rst_cnt", o_commit_cnt, 64'd0);
        n_pulses = 0;
        for (int k = 0; k < 11; k++) begin
            if (k == 3) push_wait(4'd2, 5'b01000, 32'h80000800, 32'(k));
            else        push_wait(4'd2, 5'b00000, 32'd0, 32'(k));
        end
        idle();
        for (int k = 0; k < 4; k++) step();
        check("dt_commit_cnt", o_commit_cnt, 64'd10);
        check("dt_pulses", 64'(n_pulses), 64'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
